// File: rtl/if_stage_pkg.sv
// Shared constants, IF/ID payload type and alignment helper for the fetch stage.
// Payload widths are fixed here; if_stage width parameters must match them.
package if_stage_pkg;

    localparam int IF_NADDR = 32;
    localparam int IF_NINST = 32;

    localparam logic [IF_NADDR-1:0] PC_RESET = '0;
    localparam logic [IF_NADDR-1:0] PC_STEP  = IF_NADDR'(4);
    localparam logic [IF_NINST-1:0] NOP_INST = '0;

    typedef struct packed {
        logic [IF_NADDR-1:0] pc;
        logic [IF_NINST-1:0] inst;
        logic                valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: PC_RESET, inst: NOP_INST, valid: 1'b0};

    // Fetch addresses are word addresses in byte units; low two bits are dropped.
    function automatic logic [IF_NADDR-1:0] align_pc(input logic [IF_NADDR-1:0] addr);
        return {addr[IF_NADDR-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control inputs, ROM handshake and IF/ID outputs.
interface if_stage_if #(
    parameter int NPC   = 6,
    parameter int NINST = 32,
    parameter int NADDR = 32
);
    logic             i_stall_if;
    logic             i_stall_id;
    logic             i_flush;
    logic [NADDR-1:0] i_flush_pc;
    logic             i_branch_flag;
    logic [NADDR-1:0] i_branch_target;
    logic [NINST-1:0] i_inst;
    logic             o_ce;
    logic [NPC-1:0]   o_rom_addr;
    logic [NADDR-1:0] o_pc;
    logic [NADDR-1:0] o_id_pc;
    logic [NINST-1:0] o_id_inst;
    logic             o_id_valid;

    modport master (
        input  i_stall_if, i_stall_id, i_flush, i_flush_pc,
               i_branch_flag, i_branch_target, i_inst,
        output o_ce, o_rom_addr, o_pc, o_id_pc, o_id_inst, o_id_valid
    );

    modport slave (
        output i_stall_if, i_stall_id, i_flush, i_flush_pc,
               i_branch_flag, i_branch_target, i_inst,
        input  o_ce, o_rom_addr, o_pc, o_id_pc, o_id_inst, o_id_valid
    );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush > stall_id hold > stall_if bubble > load.
// One-edge latency; a decode stall holds the current contents.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   flush,
    input  logic   stall_if,
    input  logic   stall_id,
    input  logic   ce,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q <= IF_ID_BUBBLE;
        end else if (flush || !ce) begin
            q <= IF_ID_BUBBLE;
        end else if (stall_id) begin
            q <= q;
        end else if (stall_if) begin
            q <= IF_ID_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the ROM, feeds IF/ID register.
// Fetch latency one edge from o_pc to o_id_inst; stalls hold PC, flush overrides all.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int NPC   = 6,
    parameter int NINST = IF_NINST,
    parameter int NADDR = IF_NADDR
) (
    input  logic         i_clk,
    input  logic         i_rst,
    if_stage_if.master   bus
);

    logic             ce;
    logic [NADDR-1:0] pc;
    logic             pc_hold;
    if_id_t           id_d;
    if_id_t           id_q;

    // stall_id without stall_if is illegal; treat it as a full stall.
    assign pc_hold = bus.i_stall_if | bus.i_stall_id;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ce <= 1'b0;
        end else begin
            ce <= 1'b1;
        end
    end

    // PC only moves once the ROM was already enabled on the previous edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc <= PC_RESET;
        end else if (!ce) begin
            pc <= PC_RESET;
        end else if (bus.i_flush) begin
            pc <= align_pc(bus.i_flush_pc);
        end else if (pc_hold) begin
            pc <= pc;
        end else if (bus.i_branch_flag) begin
            pc <= align_pc(bus.i_branch_target);
        end else begin
            pc <= pc + PC_STEP;
        end
    end

    assign id_d = '{pc: pc, inst: bus.i_inst, valid: ce};

    if_id_reg u_if_id_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .flush    (bus.i_flush),
        .stall_if (bus.i_stall_if),
        .stall_id (bus.i_stall_id),
        .ce       (ce),
        .d        (id_d),
        .q        (id_q)
    );

    assign bus.o_ce       = ce;
    assign bus.o_pc       = pc;
    assign bus.o_rom_addr = pc[NPC+1:2];
    assign bus.o_id_pc    = id_q.pc;
    assign bus.o_id_inst  = id_q.inst;
    assign bus.o_id_valid = id_q.valid;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the OpenMIPS pipeline; sits directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM chip-enable and word address.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles sequential fetch, branch redirect, pipeline stall and flush.

Parameters:
NPC, 6, ROM word-address width (ROM depth = 2^NPC words)
NINST, 32, instruction width
NADDR, 32, byte-address PC width

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  asynchronous active-high reset
i_stall_if  input  1  hold PC (fetch stalled)
i_stall_id  input  1  hold IF/ID register (decode stalled)
i_flush  input  1  pipeline flush (exception/eret)
i_flush_pc  input  NADDR  redirect target when i_flush=1
i_branch_flag  input  1  taken branch/jump from ID
i_branch_target  input  NADDR  branch destination byte address
i_inst  input  NINST  instruction returned combinationally by ROM
o_ce  output  1  ROM chip enable
o_rom_addr  output  NPC  ROM word address = o_pc[NPC+1:2]
o_pc  output  NADDR  current fetch PC
o_id_pc  output  NADDR  PC of instruction presented to ID
o_id_inst  output  NINST  instruction presented to ID
o_id_valid  output  1  o_id_inst is a real instruction, not a bubble

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-branch) forces: o_ce=0, o_pc=0, o_id_pc=0, o_id_inst=0, o_id_valid=0.
- First rising edge after reset release sets o_ce=1 with o_pc held at 0. o_pc may advance only on edges where o_ce was already 1.
- While o_ce=0:
  - o_pc stays 0.
  - IF/ID loads a bubble.
- PC update priority, per edge with o_ce=1:
  1. i_flush: o_pc <= i_flush_pc.
  2. i_stall_if: hold.
  3. i_branch_flag: o_pc <= i_branch_target.
  4. Otherwise: o_pc <= o_pc + 4.
- Alignment: targets (branch and flush) have bits [1:0] forced to 0 on load.
- Arithmetic: the +4 wraps modulo 2^NADDR (0xFFFFFFFC -> 0x00000000). o_rom_addr wraps modulo 2^NPC by truncation (o_pc=0x100 with NPC=6 -> addr 0).
- ROM is combinational, so i_inst corresponds to o_pc in the same cycle. Fetch latency is one edge from o_pc to o_id_inst.
- IF/ID update priority, per edge:
  1. i_flush: bubble (o_id_inst=0, o_id_pc=0, o_id_valid=0).
  2. i_stall_id=1: hold all three outputs.
  3. i_stall_if=1 and i_stall_id=0: bubble.
  4. Otherwise: o_id_pc<=o_pc, o_id_inst<=i_inst, o_id_valid<=o_ce.
- Stall combination i_stall_if=0 with i_stall_id=1 is illegal. The bench asserts it never occurs; the RTL treats it as both stalled.
- Simultaneous branch and stall_if: the branch is lost. ID must hold i_branch_flag through the stall (existing ctrl contract).
- Simultaneous flush with stall or branch: flush wins in both PC and IF/ID.
- Outputs are registered, except o_rom_addr, which is a pure slice of o_pc.

Decomposition:
- Shared package holds:
  - PC_RESET = 0
  - PC_STEP = 4
  - NOP_INST = 0
  - a typedef for the IF/ID payload struct {pc, inst, valid}
- One natural sub-module: if_id_reg, holding the IF/ID pipeline register with stall/flush/bubble priority. The PC logic stays in if_stage.

Test Plan (ROM preloaded word k = k+1):
- Reset release -> edge1: o_ce=1, o_pc=0, o_rom_addr=0. Edge2: o_pc=4, o_id_pc=0, o_id_inst=1, o_id_valid=1. Edge3: o_id_pc=4, o_id_inst=2.
- At o_pc=8: i_stall_if=i_stall_id=1 for 3 cycles -> o_pc stays 8; o_id_pc=4 and o_id_inst=2 hold. After release: o_id_inst=3, then o_pc=12.
- At o_pc=8: i_stall_if=1, i_stall_id=0 for 1 cycle -> o_id_valid=0, o_id_inst=0, o_pc stays 8. Next edge: o_id_pc=8, o_id_inst=3.
- i_branch_flag=1 with i_branch_target=0x23 -> o_pc=0x20, o_rom_addr=8. Next edge: o_id_inst=9.
- i_flush=1 with i_flush_pc=0x40, together with i_branch_flag=1 (target 0x20) and i_stall_if=1 -> o_pc=0x40 and an IF/ID bubble. Following edge: o_id_pc=0x40, o_id_inst=17.
- Sequential fetch through o_pc=0xFC -> o_rom_addr=63, inst 64. Then o_pc=0x100 gives o_rom_addr=0, inst 1. Assert i_rst mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
